// File: rtl/inst_rom_loader_pkg.sv
// Shared widths, loader state encodings and the byte-lane helper
// used by the instruction ROM loader.
package inst_rom_loader_pkg;

    localparam int INST_ADDR_BUS     = 32;
    localparam int INST_BUS          = 32;
    localparam int INST_MEM_NUM_LOG2 = 10;

    localparam logic [1:0] LD_IDLE  = 2'd0;
    localparam logic [1:0] LD_FILL  = 2'd1;
    localparam logic [1:0] LD_FLUSH = 2'd2;

    // Big-endian placement: byte 0 of a word lands in bits [31:24].
    function automatic logic [31:0] put_lane(
        input logic [31:0] w,
        input logic [1:0]  cnt,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = w;
        case (cnt)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inst_rom_loader_ram.sv
// Instruction array: one synchronous write port, one asynchronous read port.
// A same-edge write is not visible to the read port until after the edge.
module inst_ram
    import inst_rom_loader_pkg::*;
#(
    parameter int AW = INST_MEM_NUM_LOG2
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [AW-1:0]       i_waddr,
    input  logic [INST_BUS-1:0] i_wdata,
    input  logic [AW-1:0]       i_raddr,
    output logic [INST_BUS-1:0] o_rdata
);

    logic [INST_BUS-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory on the CPU fetch port, filled by a byte-serial
// big-endian loader that holds the CPU in reset while loading.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int AW = INST_MEM_NUM_LOG2,
    parameter int DW = INST_BUS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rom_ce,
    input  logic [INST_ADDR_BUS-1:0] rom_addr,
    output logic [DW-1:0]            rom_data,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic [7:0]               ld_byte,
    input  logic                     ld_last,
    output logic                     ld_ready,
    output logic                     cpu_hold,
    output logic [AW:0]              ld_words,
    output logic                     ld_overflow
);

    logic [1:0]    r_state;
    logic [AW:0]   r_word_ptr;
    logic [1:0]    r_byte_cnt;
    logic [31:0]   r_asm;
    logic [AW:0]   r_words;
    logic          r_ovf;

    logic          w_acc;
    logic          w_word_done;
    logic          w_flush;
    logic          w_commit;
    logic          w_we;
    logic [31:0]   w_asm_next;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdata;
    logic [AW:0]   w_ptr_inc;
    logic          w_unused_addr;

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    always_comb begin
        w_acc       = (r_state == LD_FILL) && ld_valid && !ld_start;
        w_asm_next  = put_lane(r_asm, r_byte_cnt, ld_byte);
        w_word_done = w_acc && (r_byte_cnt == 2'd3);
        w_flush     = (r_state == LD_FLUSH);
        w_commit    = w_word_done || w_flush;
        // Pointer saturates at the array depth; overflowing words are dropped.
        w_we        = w_commit && !r_word_ptr[AW];
        w_wdata     = w_flush ? r_asm : w_asm_next;
        w_ptr_inc   = r_word_ptr[AW] ? r_word_ptr : r_word_ptr + ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LD_IDLE;
            r_word_ptr <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_words    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_commit) begin
                r_word_ptr <= w_ptr_inc;
                r_words    <= w_ptr_inc;
                if (r_word_ptr[AW]) begin
                    r_ovf <= 1'b1;
                end
            end
            case (r_state)
                LD_IDLE: begin
                    if (ld_start) begin
                        r_state    <= LD_FILL;
                        r_word_ptr <= '0;
                        r_byte_cnt <= '0;
                        r_asm      <= '0;
                        r_words    <= '0;
                        r_ovf      <= 1'b0;
                    end
                end
                LD_FILL: begin
                    if (ld_start) begin
                        r_word_ptr <= '0;
                        r_byte_cnt <= '0;
                        r_asm      <= '0;
                        r_words    <= '0;
                        r_ovf      <= 1'b0;
                    end else if (w_acc) begin
                        if (r_byte_cnt == 2'd3) begin
                            r_asm      <= '0;
                            r_byte_cnt <= '0;
                        end else begin
                            r_asm      <= w_asm_next;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                        if (ld_last) begin
                            r_state <= (r_byte_cnt == 2'd3) ? LD_IDLE : LD_FLUSH;
                        end
                    end
                end
                LD_FLUSH: begin
                    r_asm      <= '0;
                    r_byte_cnt <= '0;
                    r_state    <= LD_IDLE;
                end
                default: r_state <= LD_IDLE;
            endcase
        end
    end

    inst_ram #(.AW(AW)) u_ram (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (r_word_ptr[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (rom_addr[AW+1:2]),
        .o_rdata (w_rdata)
    );

    // Byte offset and high address bits are deliberately ignored (aliasing).
    assign w_unused_addr = ^{rom_addr[INST_ADDR_BUS-1:AW+2], rom_addr[1:0]};

    assign rom_data    = rom_ce ? w_rdata : '0;
    assign ld_ready    = (r_state == LD_FILL);
    assign cpu_hold    = (r_state == LD_FILL) || (r_state == LD_FLUSH);
    assign ld_words    = r_words;
    assign ld_overflow = r_ovf;

endmodule
